// File: rtl/srv_mem_pkg.sv
// Shared types and helpers for the line-fill memory model.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   srv_mem_state_e   - refill FSM states
//   srv_mem_beat_addr - ROM word address for beat k of a line fill
package srv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      RESP  = 2'd3
   } srv_mem_state_e;

   // Word address read on beat k. With cwf set the burst starts at the
   // requested word and wraps inside the line, otherwise it walks the
   // line from lane 0. base has its lane bits clear, so adding a lane
   // index never carries into the line address.
   function automatic logic [63:0] srv_mem_beat_addr(
      input logic [63:0] base,
      input logic [31:0] offset,
      input logic [31:0] k,
      input logic [31:0] words,
      input logic        cwf
   );
      logic [31:0] lane;
      lane = cwf ? ((offset + k) & (words - 32'd1)) : (k & (words - 32'd1));
      return base + 64'(lane);
   endfunction

endpackage

// File: rtl/srv_mem_line_delay_ctr.sv
// Access-delay counter: pulses done on the last of DELAY wait cycles after start.
// Latency: done asserts DELAY cycles after the start cycle.
// Backpressure: none; a new start restarts the count.
//
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   start      - one-cycle pulse in the accept cycle
//   done       - one-cycle pulse in the final wait cycle
module srv_mem_delay_ctr #(
   parameter int DELAY = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic done
);
   localparam int DW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

   logic          r_busy;
   logic [DW-1:0] r_cnt;
   logic          w_last;

   assign w_last = r_busy && (r_cnt == DW'(DELAY - 1));
   assign done   = w_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
      end else if (r_busy) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/srv_mem_line.sv
// Line-fill memory model: accept a miss, wait MEM_DELAY, burst a line from ROM, pulse response.
// Latency: accept in cycle 0 -> ext_rsp_o in cycle MEM_DELAY+WORDS+1.
// Backpressure: ext_gnt_o high only in IDLE; requests in other states are ignored, never queued.
//
// Build option: define SRV_MEM_CWF_EN for critical-word-first burst ordering.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   ext_req_i / ext_addr_i    - refill request (level) and missing word address
//   ext_gnt_o                 - ready to accept
//   ext_rsp_o / ext_data_o    - one-cycle line-valid strobe, assembled line
//   rom_rd_o / rom_addr_o     - ROM read strobe and word address (zero outside bursts)
//   rom_data_i                - combinational ROM read data
module srv_mem_line
   import srv_mem_pkg::*;
#(
   parameter int LINE_W    = 128,
   parameter int WORD_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_DELAY = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ext_req_i,
   input  logic [ADDR_W-1:0] ext_addr_i,
   output logic              ext_gnt_o,
   output logic              ext_rsp_o,
   output logic [LINE_W-1:0] ext_data_o,
   output logic              rom_rd_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [WORD_W-1:0] rom_data_i
);
   localparam int WORDS = LINE_W / WORD_W;
   localparam int OFF_W = $clog2(WORDS);

`ifdef SRV_MEM_CWF_EN
   localparam logic CWF = 1'b1;
`else
   localparam logic CWF = 1'b0;
`endif

   srv_mem_state_e    r_state;
   srv_mem_state_e    w_next;
   logic [ADDR_W-1:0] r_base;
   logic [OFF_W-1:0]  r_off;
   logic [OFF_W-1:0]  r_beat;
   logic [LINE_W-1:0] r_line;

   logic              w_accept;
   logic              w_delay_done;
   logic              w_last_beat;
   logic [ADDR_W-1:0] w_beat_addr;
   logic [OFF_W-1:0]  w_lane;

   assign w_accept    = (r_state == IDLE) && ext_req_i;
   assign w_last_beat = (r_beat == OFF_W'(WORDS - 1));
   assign w_beat_addr = ADDR_W'(srv_mem_beat_addr(64'(r_base), 32'(r_off), 32'(r_beat),
                                                  32'(WORDS), CWF));
   // The base is line aligned, so the low bits of the beat address are the lane.
   assign w_lane      = w_beat_addr[OFF_W-1:0];
   assign ext_data_o  = r_line;

   generate
      if (MEM_DELAY > 0) begin : g_delay
         srv_mem_delay_ctr #(.DELAY(MEM_DELAY)) u_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .start (w_accept),
            .done  (w_delay_done)
         );
      end else begin : g_no_delay
         assign w_delay_done = 1'b0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (ext_req_i) w_next = (MEM_DELAY > 0) ? WAIT : BURST;
         WAIT:    if (w_delay_done) w_next = BURST;
         BURST:   if (w_last_beat) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      ext_gnt_o  = 1'b0;
      ext_rsp_o  = 1'b0;
      rom_rd_o   = 1'b0;
      rom_addr_o = '0;
      case (r_state)
         IDLE:  ext_gnt_o = 1'b1;
         BURST: begin
            rom_rd_o   = 1'b1;
            rom_addr_o = w_beat_addr;
         end
         RESP:  ext_rsp_o = 1'b1;
         default: ;
      endcase
   end

   // Request latch, beat counter and lane writes. Reset clears the line so
   // an aborted fill never leaves partial data visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_base <= '0;
         r_off  <= '0;
         r_beat <= '0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_base <= {ext_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_off  <= ext_addr_i[OFF_W-1:0];
            r_beat <= '0;
         end
         if (r_state == BURST) begin
            r_beat <= r_beat + 1'b1;
            for (int i = 0; i < WORDS; i++) begin
               if (w_lane == OFF_W'(i)) r_line[i*WORD_W +: WORD_W] <= rom_data_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_srv_mem_line.sv
// Bench for srv_mem_line: two instances (MEM_DELAY 3 and 0) against a cycle-indexed model.
// Latency: n/a.
// Backpressure: n/a.
module tb_srv_mem_line;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: MEM_DELAY=3, instance 1: MEM_DELAY=0
   logic         r3_n, r0_n, req3, req0;
   logic [31:0]  addr3, addr0;
   logic         gnt3, gnt0, rsp3, rsp0, rd3, rd0;
   logic [127:0] dat3, dat0;
   logic [31:0]  ra3, ra0, rom3, rom0;

   assign rom3 = 32'h1000_0000 + ra3;
   assign rom0 = 32'h1000_0000 + ra0;

   srv_mem_line #(.LINE_W(128), .WORD_W(32), .ADDR_W(32), .MEM_DELAY(3)) u_d3 (
      .clk(clk), .rst_n(r3_n), .ext_req_i(req3), .ext_addr_i(addr3),
      .ext_gnt_o(gnt3), .ext_rsp_o(rsp3), .ext_data_o(dat3),
      .rom_rd_o(rd3), .rom_addr_o(ra3), .rom_data_i(rom3));

   srv_mem_line #(.LINE_W(128), .WORD_W(32), .ADDR_W(32), .MEM_DELAY(0)) u_d0 (
      .clk(clk), .rst_n(r0_n), .ext_req_i(req0), .ext_addr_i(addr0),
      .ext_gnt_o(gnt0), .ext_rsp_o(rsp0), .ext_data_o(dat0),
      .rom_rd_o(rd0), .rom_addr_o(ra0), .rom_data_i(rom0));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   localparam int LOGN = 8192;
   bit          rsp_log [2][LOGN];
   bit          rd_log  [2][LOGN];
   bit          gnt_log [2][LOGN];
   bit          dz_log  [2][LOGN];
   logic [31:0] ra_log  [2][LOGN];

   // model state: at most one outstanding fill per instance
   bit          active   [2];
   int          acc_cyc  [2];
   logic [31:0] acc_addr [2];
   logic [31:0] mline    [2][W];

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_beat(logic [31:0] a, int k);
      logic [31:0] base;
      base = a & ~32'd3;
`ifdef SRV_MEM_CWF_EN
      return base + ((a + 32'(k)) & 32'd3);
`else
      return base + 32'(k);
`endif
   endfunction

   task automatic model_step(int id, logic rstn, logic req, logic [31:0] addr,
                             logic gnt, logic rsp, logic rd, logic [31:0] ra,
                             logic [127:0] data);
      int D, d, k;
      bit eb, er, eg;
      logic [31:0] ea;
      D  = (id == 0) ? 3 : 0;
      eb = 1'b0; er = 1'b0; ea = '0;
      eg = !active[id];
      if (active[id]) begin
         d = cyc - acc_cyc[id];
         if (d >= D + 1 && d <= D + W) begin
            eb = 1'b1;
            k  = d - D - 1;
            ea = exp_beat(acc_addr[id], k);
         end
         if (d == D + W + 1) er = 1'b1;
      end
      chk($sformatf("d%0d_gnt@%0d", id, cyc), 128'(gnt), 128'(eg));
      chk($sformatf("d%0d_rsp@%0d", id, cyc), 128'(rsp), 128'(er));
      chk($sformatf("d%0d_rd@%0d", id, cyc), 128'(rd), 128'(eb));
      chk($sformatf("d%0d_raddr@%0d", id, cyc), 128'(ra), 128'(ea));
      if (!eb)
         chk($sformatf("d%0d_line@%0d", id, cyc), data,
             {mline[id][3], mline[id][2], mline[id][1], mline[id][0]});
      if (cyc < LOGN) begin
         rsp_log[id][cyc] = rsp;
         rd_log[id][cyc]  = rd;
         gnt_log[id][cyc] = gnt;
         dz_log[id][cyc]  = (data == '0);
         ra_log[id][cyc]  = ra;
      end
      if (!rstn) begin
         active[id] = 1'b0;
         for (int i = 0; i < W; i++) mline[id][i] = '0;
      end else begin
         if (eb) mline[id][ea[1:0]] = 32'h1000_0000 + ea;
         if (er) active[id] = 1'b0;
         if (eg && req) begin
            active[id]   = 1'b1;
            acc_cyc[id]  = cyc;
            acc_addr[id] = addr;
         end
      end
   endtask

   // compare process: one model step per instance per cycle, away from the rising edge
   always @(negedge clk) begin
      if (chk_en) begin
         model_step(0, r3_n, req3, addr3, gnt3, rsp3, rd3, ra3, dat3);
         model_step(1, r0_n, req0, addr0, gnt0, rsp0, rd0, ra0, dat0);
      end
      cyc++;
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   int c0, n;
   logic [31:0] e4 [W];

   initial begin
      for (int i = 0; i < 2; i++) begin
         active[i] = 1'b0; acc_cyc[i] = 0; acc_addr[i] = '0;
         for (int j = 0; j < W; j++) mline[i][j] = '0;
      end
      r3_n = 1'b0; r0_n = 1'b0; req3 = 1'b0; req0 = 1'b0; addr3 = '0; addr0 = '0;
      repeat (3) next_cycle();
      chk_en = 1'b1;
      next_cycle();
      r3_n = 1'b1; r0_n = 1'b1;

      // reset state
      @(negedge clk); #1;
      chk("rst_gnt", 128'(gnt3), 128'd1);
      chk("rst_rsp", 128'(rsp3), 128'd0);
      chk("rst_rd", 128'(rd3), 128'd0);
      chk("rst_raddr", 128'(ra3), 128'd0);
      chk("rst_line", dat3, 128'd0);

      // single request at word 6, delay 3
      next_cycle();
      req3 = 1'b1; addr3 = 32'h6; c0 = cyc;
      next_cycle();
      req3 = 1'b0;
      repeat (10) next_cycle();
`ifdef SRV_MEM_CWF_EN
      e4[0] = 32'd6; e4[1] = 32'd7; e4[2] = 32'd4; e4[3] = 32'd5;
`else
      e4[0] = 32'd4; e4[1] = 32'd5; e4[2] = 32'd6; e4[3] = 32'd7;
`endif
      for (int k = 0; k < W; k++)
         chk($sformatf("t1_beat%0d", k), 128'(ra_log[0][c0+4+k]), 128'(e4[k]));
      chk("t1_wait_rd", 128'(rd_log[0][c0+3]), 128'd0);
      chk("t1_rsp_early", 128'(rsp_log[0][c0+7]), 128'd0);
      chk("t1_rsp", 128'(rsp_log[0][c0+8]), 128'd1);
      chk("t1_gnt_back", 128'(gnt_log[0][c0+9]), 128'd1);
      chk("t1_line", dat3, 128'h10000007_10000006_10000005_10000004);

      // zero delay, address wraps at the top of memory
      req0 = 1'b1; addr0 = 32'hFFFF_FFFD; c0 = cyc;
      next_cycle();
      req0 = 1'b0;
      repeat (8) next_cycle();
`ifdef SRV_MEM_CWF_EN
      e4[0] = 32'hFFFF_FFFD; e4[1] = 32'hFFFF_FFFE; e4[2] = 32'hFFFF_FFFF; e4[3] = 32'hFFFF_FFFC;
`else
      e4[0] = 32'hFFFF_FFFC; e4[1] = 32'hFFFF_FFFD; e4[2] = 32'hFFFF_FFFE; e4[3] = 32'hFFFF_FFFF;
`endif
      for (int k = 0; k < W; k++)
         chk($sformatf("t2_beat%0d", k), 128'(ra_log[1][c0+1+k]), 128'(e4[k]));
      chk("t2_rsp", 128'(rsp_log[1][c0+5]), 128'd1);
      chk("t2_line", dat0, 128'h0FFFFFFF_0FFFFFFE_0FFFFFFD_0FFFFFFC);

      // request held high: second accept lands in the IDLE cycle right after RESP
      req3 = 1'b1; addr3 = 32'h20; c0 = cyc;
      repeat (22) next_cycle();
      req3 = 1'b0;
      repeat (12) next_cycle();
      chk("t3_rsp_a", 128'(rsp_log[0][c0+8]), 128'd1);
      chk("t3_rsp_b", 128'(rsp_log[0][c0+17]), 128'd1);
      chk("t3_no_gnt_in_resp", 128'(gnt_log[0][c0+8]), 128'd0);
      n = 0;
      for (int i = 0; i < 20; i++) n += int'(rsp_log[0][c0+i]);
      chk("t3_rsp_count", 128'(n), 128'd2);

      // reset during beat 2 of a burst
      req3 = 1'b1; addr3 = 32'h40; c0 = cyc;
      next_cycle();
      req3 = 1'b0;
      repeat (5) next_cycle();
      r3_n = 1'b0;
      next_cycle();
      r3_n = 1'b1;
      repeat (8) next_cycle();
      chk("t4_rd_beat2", 128'(rd_log[0][c0+6]), 128'd1);
      chk("t4_idle_gnt", 128'(gnt_log[0][c0+7]), 128'd1);
      chk("t4_line_clr", 128'(dz_log[0][c0+7]), 128'd1);
      n = 0;
      for (int i = 6; i < 15; i++) n += int'(rsp_log[0][c0+i]);
      chk("t4_no_rsp", 128'(n), 128'd0);
      req3 = 1'b1; addr3 = 32'h44; c0 = cyc;
      next_cycle();
      req3 = 1'b0;
      repeat (10) next_cycle();
      chk("t4_rsp_after", 128'(rsp_log[0][c0+8]), 128'd1);
      chk("t4_line_after", dat3, 128'h10000047_10000046_10000045_10000044);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         next_cycle();
         req3  = 1'($urandom_range(0, 1));
         req0  = 1'($urandom_range(0, 1));
         addr3 = $urandom;
         addr0 = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         r3_n  = ($urandom_range(0, 99) != 0);
         r0_n  = ($urandom_range(0, 99) != 0);
      end
      next_cycle();
      req3 = 1'b0; req0 = 1'b0; r3_n = 1'b1; r0_n = 1'b1;
      repeat (20) next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
